// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the programmable waveform sequencer.
package clkgen_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int EDGE_W_DEF = 32;
    localparam int LEN_MAX_W  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    // A zero phase length would stall the down-counter, so it runs as one cycle.
    function automatic logic [LEN_MAX_W-1:0] clamp_len(input logic [LEN_MAX_W-1:0] len);
        return (len == '0) ? LEN_MAX_W'(1) : len;
    endfunction

endpackage

// File: rtl/clk_wave_sequencer_if.sv
// Control/config and status bundle between CSR logic (master) and the sequencer (slave).
interface clk_wave_sequencer_if
    import clkgen_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int EDGE_W = EDGE_W_DEF
);
    logic              start;
    logic              stop;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  low_cnt;
    logic [EDGE_W-1:0] burst_len;
    logic              wave_out;
    logic              busy;
    logic              done;
    logic [EDGE_W-1:0] edge_count;

    modport master (
        output start, stop, high_cnt, low_cnt, burst_len,
        input  wave_out, busy, done, edge_count
    );

    modport slave (
        input  start, stop, high_cnt, low_cnt, burst_len,
        output wave_out, busy, done, edge_count
    );
endinterface

// File: rtl/clkgen_phase_cnt.sv
// Loadable phase down-counter; tc flags the last cycle of the current phase.
// Latency: load takes effect next cycle. No backpressure: counts every cycle until zero.
// Holds at zero when not reloaded.
module clkgen_phase_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/clk_wave_sequencer.sv
// Programmable pulse-train sequencer: HIGH/LOW phase lengths, burst of rising edges, done pulse.
// Latency: start -> first wave_out edge 1 cycle; stop takes effect at the next period boundary.
// No backpressure; start ignored unless idle. CLKGEN_RELOAD_EN re-samples high/low each period.
module clk_wave_sequencer
    import clkgen_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int EDGE_W = EDGE_W_DEF
) (
    input logic                 clk,
    input logic                 rst_n,
    clk_wave_sequencer_if.slave bus
);
    state_t            state, state_nxt;
    logic [CNT_W-1:0]  hi_len, lo_len;
    logic [CNT_W-1:0]  high_in, low_in;
    logic [EDGE_W-1:0] burst_lat, edge_cnt;
    logic              stop_pend, stop_now, last_period;
    logic              wave_q, busy_q, done_q;
    logic              ph_load, ph_tc, start_acc, rise;
    logic [CNT_W-1:0]  ph_load_val;

    assign high_in     = CNT_W'(clamp_len(LEN_MAX_W'(bus.high_cnt)));
    assign low_in      = CNT_W'(clamp_len(LEN_MAX_W'(bus.low_cnt)));
    assign stop_now    = stop_pend | bus.stop;
    assign last_period = (burst_lat != '0) && (edge_cnt == burst_lat);

    clkgen_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_load),
        .load_val (ph_load_val),
        .tc       (ph_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        ph_load     = 1'b0;
        ph_load_val = '0;
        start_acc   = 1'b0;
        rise        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt   = HIGH;
                    ph_load     = 1'b1;
                    ph_load_val = high_in - CNT_W'(1);
                    start_acc   = 1'b1;
                end
            end
            HIGH: begin
                if (ph_tc) begin
                    state_nxt   = LOW;
                    ph_load     = 1'b1;
                    ph_load_val = lo_len - CNT_W'(1);
                end
            end
            LOW: begin
                if (ph_tc) begin
                    if (last_period || stop_now) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt = HIGH;
                        ph_load   = 1'b1;
                        rise      = 1'b1;
`ifdef CLKGEN_RELOAD_EN
                        ph_load_val = high_in - CNT_W'(1);
`else
                        ph_load_val = hi_len - CNT_W'(1);
`endif
                    end
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they change exactly with the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_len    <= '0;
            lo_len    <= '0;
            burst_lat <= '0;
            edge_cnt  <= '0;
            stop_pend <= 1'b0;
            wave_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            wave_q <= (state_nxt == HIGH);
            busy_q <= (state_nxt != IDLE);
            done_q <= (state_nxt == DONE);
            if (start_acc) begin
                hi_len    <= high_in;
                lo_len    <= low_in;
                burst_lat <= bus.burst_len;
                edge_cnt  <= EDGE_W'(1);
                stop_pend <= 1'b0;
            end else begin
                if (rise) begin
                    edge_cnt <= edge_cnt + EDGE_W'(1);
`ifdef CLKGEN_RELOAD_EN
                    hi_len   <= high_in;
                    lo_len   <= low_in;
`endif
                end
                if ((state == HIGH || state == LOW) && bus.stop) begin
                    stop_pend <= 1'b1;
                end else if (state == DONE) begin
                    stop_pend <= 1'b0;
                end
            end
        end
    end

    assign bus.wave_out   = wave_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.edge_count = edge_cnt;
endmodule

// File: tb/tb_clk_wave_sequencer.sv
// Directed bench for clk_wave_sequencer: burst table plus stop/reset/ignore/reload sequences.
module tb_clk_wave_sequencer;
    import clkgen_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clk_wave_sequencer_if #(.CNT_W(16), .EDGE_W(32)) bus ();
    clk_wave_sequencer #(.CNT_W(16), .EDGE_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int hi;
        int lo;
        int burst;
        int hw;
        int period;
        int done_at;
    } vec_t;

    vec_t vecs [5];
    int   total = 0;
    int   bad   = 0;
    int   rise_q [$];
    int   hw_q   [$];
    int   done_c;
    bit   got_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input int hi, input int lo, input int burst, input bit with_stop);
        bus.high_cnt  = hi[15:0];
        bus.low_cnt   = lo[15:0];
        bus.burst_len = burst;
        bus.start     = 1'b1;
        bus.stop      = with_stop;
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    // Samples from the first cycle after an accepted start until done or budget expiry.
    task automatic watch(input int budget, input int chg_c, input int chg_hi,
                         input int stop_edge, input int start_c);
        bit prev = 1'b0;
        bit stop_sent = 1'b0;
        int hw_run = 0;
        got_done = 1'b0;
        done_c   = -1;
        rise_q.delete();
        hw_q.delete();
        for (int c = 0; c < budget && !got_done; c++) begin
            if (c > 0) begin
                step();
                bus.stop  = 1'b0;
                bus.start = 1'b0;
            end
            if (bus.wave_out && !prev) rise_q.push_back(c);
            if (bus.wave_out) hw_run++;
            else if (prev) begin
                hw_q.push_back(hw_run);
                hw_run = 0;
            end
            prev = bus.wave_out;
            if (bus.done) begin
                got_done = 1'b1;
                done_c   = c;
            end
            if (c == chg_c) bus.high_cnt = chg_hi[15:0];
            if (c == start_c) bus.start = 1'b1;
            if (stop_edge > 0 && !stop_sent && bus.wave_out && bus.edge_count == 32'(stop_edge)) begin
                bus.stop  = 1'b1;
                stop_sent = 1'b1;
            end
        end
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        check("done_seen", got_done, 1);
    endtask

    // After done: idle next cycle, no further pulses or edges, count held.
    task automatic after_done(input int exp_edges);
        int extra = 0;
        check("final_edge_count", bus.edge_count, exp_edges);
        step();
        check("idle_busy", bus.busy, 0);
        check("idle_done", bus.done, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.done || bus.wave_out || bus.busy) extra++;
        end
        check("quiet_after_done", extra, 0);
        check("edge_count_held", bus.edge_count, exp_edges);
    endtask

    task automatic run_vec(input vec_t v);
        kick(v.hi, v.lo, v.burst, 1'b0);
        check("first_wave", bus.wave_out, 1);
        check("first_busy", bus.busy, 1);
        check("first_edge_count", bus.edge_count, 1);
        watch(1000, -1, 0, 0, -1);
        check("rise_count", rise_q.size(), v.burst);
        for (int i = 1; i < rise_q.size(); i++) check("period", rise_q[i] - rise_q[i-1], v.period);
        foreach (hw_q[i]) check("high_width", hw_q[i], v.hw);
        check("done_at", done_c, v.done_at);
        after_done(v.burst);
    endtask

    initial begin
        int found;
        vecs[0] = '{hi: 3, lo: 7, burst: 4, hw: 3, period: 10, done_at: 40};
        vecs[1] = '{hi: 0, lo: 0, burst: 2, hw: 1, period: 2,  done_at: 4};
        vecs[2] = '{hi: 1, lo: 2, burst: 3, hw: 1, period: 3,  done_at: 9};
        vecs[3] = '{hi: 5, lo: 1, burst: 1, hw: 5, period: 6,  done_at: 6};
        vecs[4] = '{hi: 2, lo: 0, burst: 3, hw: 2, period: 3,  done_at: 9};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.high_cnt  = '0;
        bus.low_cnt   = '0;
        bus.burst_len = '0;
        step();
        step();
        check("rst_wave", bus.wave_out, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_edge_count", bus.edge_count, 0);
        rst_n = 1'b1;
        step();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Continuous run stopped mid-HIGH of edge 5.
        kick(1, 1, 0, 1'b0);
        watch(200, -1, 0, 5, -1);
        check("stop_rises", rise_q.size(), 5);
        check("stop_done_at", done_c, 10);
        after_done(5);

        // Stop during the final burst period: still a single done.
        kick(1, 1, 3, 1'b0);
        watch(200, -1, 0, 3, -1);
        check("stop_last_rises", rise_q.size(), 3);
        check("stop_last_done_at", done_c, 6);
        after_done(3);

        // Start and stop together in IDLE: start wins, stop is dropped.
        kick(1, 1, 2, 1'b1);
        watch(200, -1, 0, 0, -1);
        check("start_stop_rises", rise_q.size(), 2);
        check("start_stop_done_at", done_c, 4);
        after_done(2);

        // Stop while idle must not end the next run early.
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        check("idle_stop_busy", bus.busy, 0);
        check("idle_stop_count", bus.edge_count, 2);
        kick(2, 2, 3, 1'b0);
        watch(200, -1, 0, 0, 3);
        check("busy_start_rises", rise_q.size(), 3);
        check("busy_start_done_at", done_c, 12);
        after_done(3);

        // Reset asserted during LOW aborts at once without done.
        kick(3, 7, 10, 1'b0);
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            step();
            if (bus.edge_count == 32'd2 && !bus.wave_out) found = 1;
        end
        check("reach_low", found, 1);
        rst_n = 1'b0;
        #1;
        check("abort_wave", bus.wave_out, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_edge_count", bus.edge_count, 0);
        found = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.done) found++;
        end
        check("abort_no_done", found, 0);
        rst_n = 1'b1;
        step();
        run_vec(vecs[0]);

        // Mid-run high length change: only honoured with reload enabled.
        kick(3, 7, 3, 1'b0);
        watch(200, 1, 5, 0, -1);
        check("reload_rises", rise_q.size(), 3);
        check("reload_rise2", rise_q[1], 10);
`ifdef CLKGEN_RELOAD_EN
        check("reload_rise3", rise_q[2], 22);
        check("reload_hw2", hw_q[1], 5);
        check("reload_done_at", done_c, 34);
`else
        check("reload_rise3", rise_q[2], 20);
        check("reload_hw2", hw_q[1], 3);
        check("reload_done_at", done_c, 30);
`endif
        after_done(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
